mem_lsu: RTL and testbench



---
 rtl/mem_lsu.sv | 162 ++++++++++++++++
 tb/tb_mem_lsu.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : mem_lsu
// Brief    : RV32I memory-stage load/store unit; serialises loads/stores onto
//            an 8-bit shared RAM port and stalls the pipeline meanwhile.
// Revision : 1.0 - initial release
// ============================================================================
module mem_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode_i,
    input  logic [2:0]  func3_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic        mem_gnt_i,
    input  logic [7:0]  mem_din_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        mem_req_o,
    output logic [31:0] mem_a_o,
    output logic        mem_wr_o,
    output logic [7:0]  mem_dout_o,
    output logic        stallreq
);

    localparam logic [6:0] c_op_load  = 7'b0000011;
    localparam logic [6:0] c_op_store = 7'b0100011;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_GNT = 2'd1,
        S_XFER     = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic [31:0] r_data;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_mem;
    logic [2:0]  w_nbytes;
    logic [2:0]  w_last;
    logic [2:0]  w_cnt_m1;
    logic        w_sx;
    logic [31:0] w_ext;
    logic [31:0] w_byte_addr;

    assign w_is_load   = (opcode_i == c_op_load);
    assign w_is_store  = (opcode_i == c_op_store);
    assign w_is_mem    = w_is_load | w_is_store;
    assign w_cnt_m1    = r_cnt - 3'd1;
    assign w_sx        = ~func3_i[2];
    assign w_byte_addr = mem_addr_i + {29'd0, r_cnt};

    always_comb begin
        case (func3_i[1:0])
            2'b00:   w_nbytes = 3'd1;
            2'b01:   w_nbytes = 3'd2;
            default: w_nbytes = 3'd4;
        endcase
    end

    // Loads need one extra cycle to capture the byte returned for the last address.
    assign w_last = w_is_load ? w_nbytes : (w_nbytes - 3'd1);

    always_comb begin
        case (func3_i[1:0])
            2'b00:   w_ext = {{24{w_sx & r_data[7]}},  r_data[7:0]};
            2'b01:   w_ext = {{16{w_sx & r_data[15]}}, r_data[15:0]};
            default: w_ext = r_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
            r_data  <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= 3'd0;
                    if (w_is_mem) begin
                        r_state <= S_WAIT_GNT;
                        r_data  <= 32'd0;
                    end
                end
                S_WAIT_GNT: begin
                    if (mem_gnt_i) begin
                        r_state <= S_XFER;
                        r_cnt   <= 3'd0;
                    end
                end
                S_XFER: begin
                    r_cnt <= r_cnt + 3'd1;
                    if (w_is_load && (r_cnt != 3'd0)) begin
                        r_data[{w_cnt_m1[1:0], 3'b000} +: 8] <= mem_din_i;
                    end
                    if (r_cnt == w_last) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 3'd0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        wd_o       = 5'd0;
        wreg_o     = 1'b0;
        wdata_o    = 32'd0;
        mem_req_o  = 1'b0;
        mem_a_o    = 32'd0;
        mem_wr_o   = 1'b0;
        mem_dout_o = 8'd0;
        stallreq   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_is_mem) begin
                    stallreq = 1'b1;
                end else begin
                    wd_o    = wd_i;
                    wreg_o  = wreg_i;
                    wdata_o = wdata_i;
                end
            end
            S_WAIT_GNT: begin
                mem_req_o = 1'b1;
                stallreq  = 1'b1;
            end
            S_XFER: begin
                mem_req_o = 1'b1;
                stallreq  = 1'b1;
                if (w_is_store) begin
                    mem_a_o    = w_byte_addr;
                    mem_wr_o   = 1'b1;
                    mem_dout_o = reg2_i[{r_cnt[1:0], 3'b000} +: 8];
                end else if (r_cnt < w_nbytes) begin
                    mem_a_o = w_byte_addr;
                end
            end
            S_DONE: begin
                wd_o    = wd_i;
                wreg_o  = wreg_i;
                wdata_o = w_is_load ? w_ext : 32'd0;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_lsu
// Brief    : Scoreboard testbench for mem_lsu with a byte-array RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_lsu;

    localparam logic [6:0] c_op_load  = 7'b0000011;
    localparam logic [6:0] c_op_store = 7'b0100011;
    localparam logic [6:0] c_op_alu   = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  opcode = c_op_alu;
    logic [2:0]  func3 = 3'd0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] reg2 = 32'd0;
    logic [4:0]  wd = 5'd0;
    logic        wreg = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic        mem_gnt = 1'b0;
    logic [7:0]  mem_din = 8'd0;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        mem_req;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic        stallreq;

    always #5 clk = ~clk;

    mem_lsu dut (
        .clk        (clk),
        .rst        (rst),
        .opcode_i   (opcode),
        .func3_i    (func3),
        .mem_addr_i (mem_addr),
        .reg2_i     (reg2),
        .wd_i       (wd),
        .wreg_i     (wreg),
        .wdata_i    (wdata),
        .mem_gnt_i  (mem_gnt),
        .mem_din_i  (mem_din),
        .wd_o       (wd_o),
        .wreg_o     (wreg_o),
        .wdata_o    (wdata_o),
        .mem_req_o  (mem_req),
        .mem_a_o    (mem_a),
        .mem_wr_o   (mem_wr),
        .mem_dout_o (mem_dout),
        .stallreq   (stallreq)
    );

    typedef struct {
        bit          is_store;
        logic [31:0] addr;
        logic [31:0] sdata;
        int          nbytes;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        int          stall;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e_m;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  ram     [64];
    logic [7:0]  ref_mem [64];
    logic        ram_init = 1'b1;
    logic        poke_en  = 1'b0;
    logic [31:0] poke_addr = 32'd0;
    logic [7:0]  poke_data = 8'd0;
    int          gnt_delay = 0;
    int          gwait = 0;
    bit          skip_mon = 1'b1;
    int          stall_cnt = 0;
    int          wr_k = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // RAM aliased on the low 6 address bits; read data appears one cycle after the address.
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 64; i++) ram[i] <= 8'(i * 29 + 7);
        end else if (poke_en) begin
            ram[poke_addr[5:0]] <= poke_data;
        end else if (mem_req && mem_wr) begin
            ram[mem_a[5:0]] <= mem_dout;
        end
        mem_din <= ram[mem_a[5:0]];
    end

    // Arbiter: withholds the grant for gnt_delay cycles, then holds it while requested.
    always @(negedge clk) begin
        if (!mem_req) begin
            mem_gnt = 1'b0;
            gwait   = 0;
        end else if (gwait >= gnt_delay) begin
            mem_gnt = 1'b1;
        end else begin
            gwait++;
        end
    end

    always @(negedge clk) begin
        if (rst || skip_mon) begin
            stall_cnt = 0;
            wr_k      = 0;
        end else begin
            if (mem_wr) begin
                if (exp_q.size() == 0 || !exp_q[0].is_store || wr_k >= exp_q[0].nbytes) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr 0x%08h data 0x%02h, required no write", mem_a, mem_dout);
                end else begin
                    check("wr_addr", mem_a, exp_q[0].addr + 32'(wr_k));
                    check("wr_data", {24'd0, mem_dout}, {24'd0, exp_q[0].sdata[8*wr_k +: 8]});
                end
                wr_k++;
            end
            if (stallreq) begin
                stall_cnt++;
            end else begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_retire: got wdata 0x%08h, required no retirement", wdata_o);
                end else begin
                    e_m = exp_q.pop_front();
                    check("wd",      {27'd0, wd_o}, {27'd0, e_m.wd});
                    check("wreg",    {31'd0, wreg_o}, {31'd0, e_m.wreg});
                    check("wdata",   wdata_o, e_m.wdata);
                    check("stall",   32'(stall_cnt), 32'(e_m.stall));
                    check("n_write", 32'(wr_k), e_m.is_store ? 32'(e_m.nbytes) : 32'd0);
                    check("req_idle", {31'd0, mem_req}, 32'd0);
                end
                stall_cnt = 0;
                wr_k      = 0;
            end
        end
    end

    task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] r2, input logic [4:0] d, input logic w,
                         input logic [31:0] wdat);
        opcode   = opc;
        func3    = f3;
        mem_addr = addr;
        reg2     = r2;
        wd       = d;
        wreg     = w;
        wdata    = wdat;
    endtask

    // Reference model: computes the retirement record from the byte-level memory image.
    task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] r2, input logic [4:0] d, input logic w,
                         input logic [31:0] wdat, input int dly, input int n_store);
        exp_t        e;
        int          n;
        longint      v;
        logic [31:0] a;
        logic [31:0] t;
        int          guard;
        n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        e.is_store = (opc == c_op_store);
        e.addr     = addr;
        e.sdata    = r2;
        e.nbytes   = n;
        e.wd       = d;
        e.wreg     = w;
        if (opc == c_op_load) begin
            v = 0;
            for (int k = 0; k < n; k++) begin
                a = addr + 32'(k);
                v = v + (longint'(ref_mem[a[5:0]]) << (8 * k));
            end
            if (!f3[2] && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
            e.wdata = v[31:0];
            e.stall = n + 3 + dly;
        end else if (opc == c_op_store) begin
            for (int k = 0; k < n && k < n_store; k++) begin
                a = addr + 32'(k);
                t = r2 >> (8 * k);
                ref_mem[a[5:0]] = t[7:0];
            end
            e.wdata = 32'd0;
            e.stall = n + 2 + dly;
        end else begin
            e.wdata = wdat;
            e.stall = 0;
        end
        gnt_delay = dly;
        drive(opc, f3, addr, r2, d, w, wdat);
        exp_q.push_back(e);
        if (n_store >= n || opc != c_op_store) begin
            guard = 0;
            do begin
                @(negedge clk);
                guard++;
            end while (stallreq && guard < 100);
            if (guard >= 100) begin
                n_tests++;
                n_fail++;
                $display("FAIL timeout: got stallreq stuck high, required release within 100 cycles");
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic poke(input logic [31:0] addr, input logic [7:0] data);
        ref_mem[addr[5:0]] = data;
        poke_addr = addr;
        poke_data = data;
        poke_en   = 1'b1;
        issue(c_op_alu, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0, 0, 4);
        poke_en   = 1'b0;
    endtask

    initial begin
        int          k;
        int          guard;
        int          sel;
        logic [2:0]  f3;
        for (int i = 0; i < 64; i++) ref_mem[i] = 8'(i * 29 + 7);
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        ram_init = 1'b0;
        @(negedge clk);
        check("rst_stall", {31'd0, stallreq}, 32'd0);
        check("rst_req",   {31'd0, mem_req}, 32'd0);
        check("rst_wdata", wdata_o, 32'd0);
        check("rst_wreg",  {31'd0, wreg_o}, 32'd0);
        @(posedge clk);
        #1;
        skip_mon = 1'b0;

        poke(32'h0000_1000, 8'h78);
        poke(32'h0000_1001, 8'h56);
        poke(32'h0000_1002, 8'h34);
        poke(32'h0000_1003, 8'h12);
        issue(c_op_load, 3'b010, 32'h0000_1000, 32'd0, 5'd7, 1'b1, 32'd0, 0, 4);
        poke(32'h0000_2003, 8'h80);
        issue(c_op_load, 3'b000, 32'h0000_2003, 32'd0, 5'd8, 1'b1, 32'd0, 0, 4);
        issue(c_op_load, 3'b100, 32'h0000_2003, 32'd0, 5'd9, 1'b1, 32'd0, 0, 4);
        poke(32'h0000_2002, 8'h80);
        poke(32'h0000_2003, 8'hFF);
        issue(c_op_load, 3'b001, 32'h0000_2002, 32'd0, 5'd10, 1'b1, 32'd0, 0, 4);
        issue(c_op_store, 3'b001, 32'hFFFF_FFFF, 32'hAABB_CCDD, 5'd0, 1'b0, 32'd0, 0, 4);
        issue(c_op_load, 3'b101, 32'hFFFF_FFFF, 32'd0, 5'd11, 1'b1, 32'd0, 0, 4);
        issue(c_op_store, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 5'd0, 1'b0, 32'd0, 3, 4);
        issue(c_op_alu, 3'b000, 32'd0, 32'd0, 5'd3, 1'b1, 32'h0000_0005, 0, 4);

        // SW abandoned by reset while its third byte (cnt = 2) is on the port.
        issue(c_op_store, 3'b010, 32'h0000_0020, 32'h1122_3344, 5'd0, 1'b0, 32'd0, 0, 3);
        k = 0;
        guard = 0;
        while (k < 3 && guard < 50) begin
            @(negedge clk);
            guard++;
            if (mem_wr) k++;
        end
        if (k < 3) begin
            n_tests++;
            n_fail++;
            $display("FAIL rst_setup: got %0d writes, required 3", k);
        end
        skip_mon = 1'b1;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(c_op_alu, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
        @(negedge clk);
        check("mid_rst_stall", {31'd0, stallreq}, 32'd0);
        check("mid_rst_req",   {31'd0, mem_req}, 32'd0);
        check("mid_rst_wr",    {31'd0, mem_wr}, 32'd0);
        check("mid_rst_addr",  mem_a, 32'd0);
        check("mid_rst_dout",  {24'd0, mem_dout}, 32'd0);
        check("mid_rst_wd",    {27'd0, wd_o}, 32'd0);
        check("mid_rst_wreg",  {31'd0, wreg_o}, 32'd0);
        check("mid_rst_wdata", wdata_o, 32'd0);
        void'(exp_q.pop_front());
        @(posedge clk);
        #1;
        skip_mon = 1'b0;
        issue(c_op_load, 3'b010, 32'h0000_0020, 32'd0, 5'd12, 1'b1, 32'd0, 0, 4);

        for (int it = 0; it < 120; it++) begin
            sel = $urandom_range(0, 2);
            f3  = 3'($urandom_range(0, 2));
            if (sel == 1 && $urandom_range(0, 1) == 1 && f3 != 3'd2) f3[2] = 1'b1;
            issue(sel == 0 ? c_op_alu : sel == 1 ? c_op_load : c_op_store, f3,
                  (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : 32'd0) | $urandom,
                  $urandom, 5'($urandom), 1'($urandom), $urandom,
                  $urandom_range(0, 3), 4);
        end

        for (int i = 0; i < 64; i++) begin
            check("ram_image", {24'd0, ram[i]}, {24'd0, ref_mem[i]});
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL pending: got %0d unretired, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
